// File: rtl/mult_div_unit.sv
// Multiply/divide unit with HI/LO result registers and a fixed-latency busy handshake.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU (accumulate into {hi,lo}); otherwise those codes are no-ops.
module mult_div_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       mdOp,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               is_mul, is_div, finish, accept;
    logic [2*WIDTH-1:0] result;

    // Operands are extended to 2*WIDTH so one truncating multiply serves both signednesses.
    function automatic logic [2*WIDTH-1:0] mul_op(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic               sgn;
        logic [2*WIDTH-1:0] ea, eb;
        sgn = (op == OP_MULT);
`ifdef MDU_MADD_EN
        sgn = sgn || (op == OP_MADD) || (op == OP_MSUB);
`endif
        ea = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        eb = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        return ea * eb;
    endfunction

    // Sign-magnitude divide; most-negative / -1 wraps back to most-negative with zero remainder.
    function automatic logic [2*WIDTH-1:0] div_op(input logic sgn,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic             neg_a, neg_b;
        logic [WIDTH-1:0] ma, mb, q, r;
        neg_a = sgn && a[WIDTH-1];
        neg_b = sgn && b[WIDTH-1];
        if (b == '0) begin
            q = '1;
            r = a;
        end else begin
            ma = neg_a ? -a : a;
            mb = neg_b ? -b : b;
            q  = ma / mb;
            r  = ma % mb;
            if (neg_a ^ neg_b) q = -q;
            if (neg_a) r = -r;
        end
        return {r, q};
    endfunction

    always_comb begin
        is_mul = (mdOp == OP_MULT) || (mdOp == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (mdOp == OP_MADD) || (mdOp == OP_MADDU) ||
                 (mdOp == OP_MSUB) || (mdOp == OP_MSUBU);
`endif
        is_div = (mdOp == OP_DIV) || (mdOp == OP_DIVU);
    end

    assign busy   = (state != IDLE);
    assign finish = (state != IDLE) && (cnt == CNT_W'(1));
    // A new request may ride the same edge that retires the current one.
    assign accept = start && ((state == IDLE) || finish);

    always_comb begin
        if (state == DIV) begin
            result = div_op(op_q == OP_DIV, a_q, b_q);
        end else begin
            result = mul_op(op_q, a_q, b_q);
`ifdef MDU_MADD_EN
            if ((op_q == OP_MADD) || (op_q == OP_MADDU))
                result = {hi, lo} + result;
            else if ((op_q == OP_MSUB) || (op_q == OP_MSUBU))
                result = {hi, lo} - result;
`endif
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (finish) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (state != IDLE) begin
            cnt_next = cnt - CNT_W'(1);
        end
        if (accept && is_mul) begin
            state_next = MUL;
            cnt_next   = CNT_W'(MUL_LAT);
        end else if (accept && is_div) begin
            state_next = DIV;
            cnt_next   = CNT_W'(DIV_LAT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && (is_mul || is_div)) begin
            op_q <= mdOp;
            a_q  <= srcA;
            b_q  <= srcB;
        end
    end

    // Moves accepted on a retiring edge land after the result, so they take precedence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (finish) {hi, lo} <= result;
            if (accept && (mdOp == OP_MTHI)) hi <= srcA;
            if (accept && (mdOp == OP_MTLO)) lo <= srcA;
        end
    end
endmodule
